// File: rtl/eeprom_port_arbiter.sv
// Round-robin sequencer sharing the single EEPROM image RAM port between host (H) and serial slave (S).
// Optional S-write protection of addresses >= WP_BASE is built when EEPROM_WP_EN is defined.
module eeprom_port_arbiter #(
    parameter logic [15:0] WP_BASE = 16'hF000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        h_req,
    input  logic        h_wen,
    input  logic [15:0] h_addr,
    input  logic [7:0]  h_din,
    output logic        h_ack,
    output logic [7:0]  h_dout,
    input  logic        s_req,
    input  logic        s_wen,
    input  logic [15:0] s_addr,
    input  logic [7:0]  s_din,
    output logic        s_ack,
    output logic [7:0]  s_dout,
    output logic        ram_wen,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout,
    input  logic        wp,
    output logic        wp_err,
    output logic        busy
);
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e          state_q, state_d;
    logic            last_s_q, last_s_d;
    logic            cur_s_q, cur_s_d;
    logic            ram_wen_q, ram_wen_d;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [DW-1:0]   ram_din_q, ram_din_d;
    logic            h_ack_q, h_ack_d;
    logic            s_ack_q, s_ack_d;
    logic [DW-1:0]   h_dout_q, h_dout_d;
    logic [DW-1:0]   s_dout_q, s_dout_d;
    logic            busy_q, busy_d;
    logic            win_s_c;
    logic            blk_c;

    // H wins unless S is alone, or both ask and H was served last
    assign win_s_c = s_req && (!h_req || !last_s_q);

`ifdef EEPROM_WP_EN
    logic blk_q, blk_d;
    logic wp_err_q, wp_err_d;

    assign blk_c  = win_s_c && s_wen && wp && (s_addr >= WP_BASE);
    assign wp_err = wp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_q    <= 1'b0;
            wp_err_q <= 1'b0;
        end else begin
            blk_q    <= blk_d;
            wp_err_q <= wp_err_d;
        end
    end

    // Suppressed-write flag follows the transaction and pulses wp_err alongside the ack
    always_comb begin
        blk_d    = blk_q;
        wp_err_d = 1'b0;
        if (state_q == IDLE && (h_req || s_req)) blk_d = blk_c;
        if (state_q == WAIT) wp_err_d = blk_q;
    end
`else
    logic unused_ok;

    assign blk_c     = 1'b0;
    assign wp_err    = 1'b0;
    assign unused_ok = ^{wp, WP_BASE};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_s_q   <= 1'b1;
            cur_s_q    <= 1'b0;
            ram_wen_q  <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            h_ack_q    <= 1'b0;
            s_ack_q    <= 1'b0;
            h_dout_q   <= '0;
            s_dout_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_s_q   <= last_s_d;
            cur_s_q    <= cur_s_d;
            ram_wen_q  <= ram_wen_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            h_ack_q    <= h_ack_d;
            s_ack_q    <= s_ack_d;
            h_dout_q   <= h_dout_d;
            s_dout_q   <= s_dout_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state and registered-output logic; ram_wen_d is set on IDLE exit so ram_wen is high only in ISSUE
    always_comb begin
        state_d    = state_q;
        last_s_d   = last_s_q;
        cur_s_d    = cur_s_q;
        ram_wen_d  = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        h_ack_d    = 1'b0;
        s_ack_d    = 1'b0;
        h_dout_d   = h_dout_q;
        s_dout_d   = s_dout_q;

        case (state_q)
            IDLE: begin
                if (h_req || s_req) begin
                    cur_s_d    = win_s_c;
                    last_s_d   = win_s_c;
                    ram_wen_d  = (win_s_c ? s_wen : h_wen) && !blk_c;
                    ram_addr_d = win_s_c ? s_addr : h_addr;
                    ram_din_d  = win_s_c ? s_din : h_din;
                    state_d    = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (cur_s_q) begin
                    s_dout_d = ram_dout;
                    s_ack_d  = 1'b1;
                end else begin
                    h_dout_d = ram_dout;
                    h_ack_d  = 1'b1;
                end
                state_d = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign h_ack    = h_ack_q;
    assign s_ack    = s_ack_q;
    assign h_dout   = h_dout_q;
    assign s_dout   = s_dout_q;
    assign ram_wen  = ram_wen_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_eeprom_port_arbiter.sv
// Directed bench for eeprom_port_arbiter with a behavioural write-through RAM model.
module tb_eeprom_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        h_req = 1'b0, h_wen = 1'b0;
    logic [15:0] h_addr = '0;
    logic [7:0]  h_din = '0;
    logic        h_ack;
    logic [7:0]  h_dout;
    logic        s_req = 1'b0, s_wen = 1'b0;
    logic [15:0] s_addr = '0;
    logic [7:0]  s_din = '0;
    logic        s_ack;
    logic [7:0]  s_dout;
    logic        ram_wen;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout = '0;
    logic        wp = 1'b0;
    logic        wp_err;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [65536];

    eeprom_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .h_req(h_req), .h_wen(h_wen), .h_addr(h_addr), .h_din(h_din), .h_ack(h_ack), .h_dout(h_dout),
        .s_req(s_req), .s_wen(s_wen), .s_addr(s_addr), .s_din(s_din), .s_ack(s_ack), .s_dout(s_dout),
        .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .wp(wp), .wp_err(wp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Registered RAM; a write returns the new byte on ram_dout
    always @(posedge clk) begin
        if (ram_wen) begin
            mem[ram_addr] <= ram_din;
            ram_dout      <= ram_din;
        end else begin
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " h_ack"}, 32'(h_ack), 32'h0);
        chk({nm, " s_ack"}, 32'(s_ack), 32'h0);
        chk({nm, " h_dout"}, 32'(h_dout), 32'h0);
        chk({nm, " s_dout"}, 32'(s_dout), 32'h0);
        chk({nm, " ram_wen"}, 32'(ram_wen), 32'h0);
        chk({nm, " ram_addr"}, 32'(ram_addr), 32'h0);
        chk({nm, " ram_din"}, 32'(ram_din), 32'h0);
        chk({nm, " wp_err"}, 32'(wp_err), 32'h0);
        chk({nm, " busy"}, 32'(busy), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single transaction from one requester; checks latency, data, wp_err and isolation of the other side
    task automatic xact(input logic is_s, input logic wen, input logic [15:0] addr, input logic [7:0] din,
                        input logic [7:0] exp_d, input logic exp_err, input string nm);
        int cnt;
        logic got;
        logic [7:0] other;
        @(negedge clk);
        if (is_s) begin
            s_req = 1'b1; s_wen = wen; s_addr = addr; s_din = din; other = h_dout;
        end else begin
            h_req = 1'b1; h_wen = wen; h_addr = addr; h_din = din; other = s_dout;
        end
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 20) begin
            @(negedge clk);
            cnt++;
            got = is_s ? s_ack : h_ack;
        end
        h_req = 1'b0;
        s_req = 1'b0;
        chk({nm, " latency"}, 32'(cnt), 32'd3);
        if (got) begin
            chk({nm, " dout"}, 32'(is_s ? s_dout : h_dout), 32'(exp_d));
            chk({nm, " wp_err"}, 32'(wp_err), 32'(exp_err));
            chk({nm, " other ack"}, 32'(is_s ? h_ack : s_ack), 32'h0);
            chk({nm, " other dout"}, 32'(is_s ? h_dout : s_dout), 32'(other));
            chk({nm, " busy"}, 32'(busy), 32'h1);
        end
    endtask

    typedef struct {
        logic        is_s;
        logic        wen;
        logic [15:0] addr;
        logic [7:0]  din;
        logic [7:0]  exp_d;
    } vec_t;

    vec_t vecs [9];
    int   seq [8];

    initial begin
        int th, ts, idx, nh, ns, ovl;
        logic [7:0] hd, sd;
        logic ack_seen;

        vecs[0] = '{1'b0, 1'b1, 16'h0010, 8'hA5, 8'hA5};
        vecs[1] = '{1'b0, 1'b0, 16'h0010, 8'h00, 8'hA5};
        vecs[2] = '{1'b0, 1'b1, 16'h0000, 8'h11, 8'h11};
        vecs[3] = '{1'b1, 1'b1, 16'h0001, 8'h22, 8'h22};
        vecs[4] = '{1'b1, 1'b0, 16'h0000, 8'h00, 8'h11};
        vecs[5] = '{1'b0, 1'b0, 16'h0001, 8'h00, 8'h22};
        vecs[6] = '{1'b1, 1'b1, 16'hFFFF, 8'h3C, 8'h3C};
        vecs[7] = '{1'b0, 1'b0, 16'hFFFF, 8'h00, 8'h3C};
        vecs[8] = '{1'b1, 1'b0, 16'h0010, 8'h00, 8'hA5};

        #1;
        chk_reset_vals("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            xact(vecs[i].is_s, vecs[i].wen, vecs[i].addr, vecs[i].din, vecs[i].exp_d, 1'b0,
                 $sformatf("vec%0d", i));

        // Contended reads right after reset: H wins, S follows one transaction later
        do_reset();
        @(negedge clk);
        h_req = 1'b1; h_wen = 1'b0; h_addr = 16'h0000;
        s_req = 1'b1; s_wen = 1'b0; s_addr = 16'h0001;
        th = -1; ts = -1; hd = '0; sd = '0;
        for (int c = 1; c <= 20 && ts < 0; c++) begin
            @(negedge clk);
            if (h_ack) begin th = c; hd = h_dout; h_req = 1'b0; end
            if (s_ack) begin ts = c; sd = s_dout; s_req = 1'b0; end
        end
        h_req = 1'b0; s_req = 1'b0;
        chk("contend h latency", 32'(th), 32'd3);
        chk("contend s after h", 32'(ts - th), 32'd4);
        chk("contend h_dout", 32'(hd), 32'h11);
        chk("contend s_dout", 32'(sd), 32'h22);

        // Both requesters held for four transactions each
        @(negedge clk);
        h_req = 1'b1; h_wen = 1'b0; h_addr = 16'h0010;
        s_req = 1'b1; s_wen = 1'b0; s_addr = 16'h0001;
        idx = 0; nh = 0; ns = 0; ovl = 0;
        for (int c = 0; c < 80 && idx < 8; c++) begin
            @(negedge clk);
            if (h_ack && s_ack) ovl++;
            if (h_ack) begin seq[idx] = 0; idx++; nh++; if (nh == 4) h_req = 1'b0; end
            else if (s_ack) begin seq[idx] = 1; idx++; ns++; if (ns == 4) s_req = 1'b0; end
        end
        h_req = 1'b0; s_req = 1'b0;
        chk("alt ack count", 32'(idx), 32'd8);
        chk("alt overlap", 32'(ovl), 32'd0);
        for (int i = 0; i < idx; i++)
            chk($sformatf("alt grant %0d", i), 32'(seq[i]), 32'(i % 2));

        // Write protection at the region boundary
        xact(1'b0, 1'b1, 16'hF000, 8'hFF, 8'hFF, 1'b0, "wp preload");
        wp = 1'b1;
`ifdef EEPROM_WP_EN
        xact(1'b1, 1'b1, 16'hF000, 8'h55, 8'hFF, 1'b1, "wp s write");
        xact(1'b1, 1'b0, 16'hF000, 8'h00, 8'hFF, 1'b0, "wp s readback");
        xact(1'b1, 1'b1, 16'hEFFF, 8'h66, 8'h66, 1'b0, "wp below base");
`else
        xact(1'b1, 1'b1, 16'hF000, 8'h55, 8'h55, 1'b0, "wp s write");
        xact(1'b1, 1'b0, 16'hF000, 8'h00, 8'h55, 1'b0, "wp s readback");
`endif
        xact(1'b0, 1'b1, 16'hF000, 8'h77, 8'h77, 1'b0, "wp h write");
        xact(1'b1, 1'b0, 16'hF000, 8'h00, 8'h77, 1'b0, "wp h readback");
        wp = 1'b0;

        // Reset pulled during ISSUE of an H read
        @(negedge clk);
        h_req = 1'b1; h_wen = 1'b0; h_addr = 16'h0010;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid reset");
        h_req = 1'b0;
        ack_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (h_ack) ack_seen = 1'b1;
        end
        chk("mid reset no ack", 32'(ack_seen), 32'h0);
        rst_n = 1'b1;
        xact(1'b0, 1'b0, 16'h0010, 8'h00, 8'hA5, 1'b0, "post reset read");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/eeprom_port_arbiter.md
# eeprom_port_arbiter

Sequencer and two-way arbiter in front of the 64 KiB byte-wide single-port EEPROM image RAM. It shares the RAM's one port between the host-side requester (H) and the serial-slave requester (S). It turns each request/acknowledge transaction into a correctly timed RAM cycle and returns read data. It sits between the EEPROM image RAM and the board's host/serial front ends, and owns every RAM control signal.

## Interface
- WP_BASE, 16'hF000, first address of the write-protected region (used only with EEPROM_WP_EN).
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- h_req  in  1  host request; level, held with h_wen/h_addr/h_din stable until h_ack.
- h_wen  in  1  1 = write, 0 = read.
- h_addr  in  16  byte address.
- h_din  in  8  write data.
- h_ack  out  1  one-cycle completion pulse.
- h_dout  out  8  read data, valid while h_ack=1, held afterwards.
- s_req, s_wen, s_addr, s_din, s_ack, s_dout: same as the h_* set, for the serial slave.
- ram_wen  out  1  RAM write enable.
- ram_addr  out  16  RAM address.
- ram_din  out  8  RAM write data.
- ram_dout  in  8  RAM read data (registered; valid one cycle after address with ram_wen=0).
- wp  in  1  write-protect enable for S writes.
- wp_err  out  1  one-cycle pulse when an S write is suppressed.
- busy  out  1  high whenever state != IDLE.

## Operation
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. No other transitions except reset.
- IDLE: if any req=1, pick a winner, latch its wen/addr/din into ram_* registers, record the grant, go to ISSUE. Otherwise stay in IDLE.
- Arbitration: round-robin. With a single requester, it wins. With both, the one not granted last wins. The last-grant register resets to S, so H wins the first contended cycle.
- ISSUE: ram_wen = latched wen (write committed at end of cycle). ram_addr and ram_din are stable.
- WAIT: ram_wen=0. ram_dout now reflects ram_addr. Capture ram_dout into the granted requester's dout, even for writes; for a write the captured value is the just-written byte.
- RESP: the granted requester's ack=1. The requester's req is ignored in this cycle. Return to IDLE.
- A requester that keeps req=1 after its ack starts a new transaction. It is then arbitrated normally against the other requester.
- The non-granted requester's ack and dout are untouched.
- ram_wen is 1 only in ISSUE. ram_addr and ram_din hold their last value outside ISSUE.
- Reset values: state=IDLE, h_ack=s_ack=0, h_dout=s_dout=8'h00, ram_wen=0, ram_addr=16'h0000, ram_din=8'h00, wp_err=0, busy=0, last grant=S.
- Reset asserted mid-transaction aborts it immediately. A write already in ISSUE may or may not land in the RAM. No ack is issued.

## Timing
- req sampled high in IDLE at edge k: ISSUE in cycle k+1, WAIT in k+2, ack=1 in k+3. Latency is 3 cycles to ack for both reads and writes.
- Back-to-back throughput: one transaction per 4 cycles.
- A contended second requester waits at most one transaction: 4 cycles plus its own 3.

## Configuration
- EEPROM_WP_EN defined: an S write with s_addr >= WP_BASE while wp=1 drives ram_wen=0 in ISSUE. The RAM is unchanged. The write is still acked normally. wp_err pulses in the RESP cycle. H writes are never blocked.
- EEPROM_WP_EN undefined: wp is ignored, wp_err is tied 0, and all writes are committed.

## Test plan
- Reset released, H writes 8'hA5 to 16'h0010, then reads it back. Required: each h_ack arrives exactly 3 cycles after the req sample, and read h_dout=8'hA5.
- H and S both raise req in the same cycle, reading 16'h0000 and 16'h0001 (preloaded 8'h11/8'h22). Required: H is served first with h_dout=8'h11, then S with s_dout=8'h22; s_ack comes 4 cycles after h_ack.
- Both hold req high for 4 transactions each. Required: grants strictly alternate H,S,H,S and no ack overlaps.
- EEPROM_WP_EN defined, wp=1, S writes 8'h55 to 16'hF000 (preloaded 8'hFF). Required: s_ack=1, wp_err=1 in the same cycle, and a subsequent read returns 8'hFF. An H write to the same address is committed.
- rst_n is pulled low during ISSUE of an H read. Required: all outputs return to reset values asynchronously, no h_ack occurs, and a new request after release completes normally.
